uart_tx: RTL and testbench
==========================

Name: uart_tx

Overview:
- UART transmitter; the consumer end of the UART TX FIFO.
- Pops bytes from the FIFO read port and serializes them as 8N1 (optionally 8E1) frames on tx_o, LSB first.
- Sits between the bus-side TX FIFO and the SoC's serial pin.
- Assumes the FIFO's registered read: data is valid on rd_data the cycle after rd_en.

Parameters:
- DataBits, 8, payload bits per frame (5..9).
- ClksPerBit, 868, clk_i cycles per bit period (100 MHz / 115200); must be >= 2.
- StopBits, 1, number of stop bits (1 or 2).

Ports:
- clk_i  input  1  system clock, rising edge.
- rst_ni  input  1  reset, asynchronous, active-low.
- tx_en_i  input  1  enable; when low, no new frame starts.
- fifo_empty_i  input  1  TX FIFO empty flag.
- fifo_rd_data_i  input  DataBits  TX FIFO read data, valid the cycle after fifo_rd_en_o.
- fifo_rd_en_o  output  1  FIFO pop request, registered, one-cycle pulse.
- tx_o  output  1  serial line, idle high, registered.
- busy_o  output  1  high in any state other than IDLE.

Behaviour:
- Reset (async assert, sync deassert externally): state=IDLE, tx_o=1, fifo_rd_en_o=0, busy_o=0, baud and bit counters=0, shift register=0.
- States: IDLE, REQ, LOAD, START, DATA, [PARITY], STOP.
- IDLE: at an edge with tx_en_i=1 and fifo_empty_i=0, go to REQ and set fifo_rd_en_o<=1.
- REQ: fifo_rd_en_o<=0 (exactly one pulse per frame); go to LOAD. The FIFO updates rd_data at this edge.
- LOAD: shift <= fifo_rd_data_i, tx_o<=0, baud counter <= 0, go to START.
- Start timing: tx_o falls at edge k+2, where k is the IDLE edge that issued the request.
- START: hold tx_o=0 for ClksPerBit cycles. On expiry: tx_o<=shift[0], bit counter <= 0, go to DATA.
- DATA: every ClksPerBit cycles, shift right and drive the next bit. After DataBits bits, go to PARITY (if enabled) or STOP with tx_o<=1.
- STOP: tx_o=1 for StopBits*ClksPerBit cycles, then go to IDLE.
- Back-to-back frames: minimum line-high time between frames is StopBits*ClksPerBit+3 cycles.
- Baud counter: width $clog2(ClksPerBit), counts 0..ClksPerBit-1, wraps to 0 on each bit boundary.
- Bit counter: width $clog2(DataBits+1).
- tx_en_i dropped mid-frame: the current frame completes; no new request is made.
- tx_en_i dropped during REQ/LOAD: the popped byte is still sent and never dropped.
- fifo_empty_i is sampled only in IDLE; its value in other states is ignored.
- Reset mid-frame: tx_o returns to 1 immediately (async); the in-flight byte is lost and the FIFO is not rewound.
- busy_o is asserted from the REQ edge until the IDLE edge.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined: PARITY state inserted after DATA, driving the even-parity bit (XOR of payload bits) for ClksPerBit cycles; frame is 1+DataBits+1+StopBits bits.
- Undefined: the PARITY state and its XOR logic do not exist; DATA goes directly to STOP.

Decomposition:
- uart_pkg holds the tx_state_e enum (IDLE, REQ, LOAD, START, DATA, PARITY, STOP), default constants (DEFAULT_CLKS_PER_BIT=868, DEFAULT_DATA_BITS=8), and an even-parity function.
- One sub-module, uart_baud_gen: counter with ClksPerBit parameter, clr_i input, tick_o output (one-cycle pulse at the bit boundary). Shared later with uart_rx.

Test Plan:
- ClksPerBit=4, push 0xA5 into the FIFO, tx_en_i=1 -> one rd_en pulse; tx_o = 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles; busy_o falls after stop.
- FIFO empty, tx_en_i=1 for 100 cycles -> fifo_rd_en_o never asserted, tx_o=1, busy_o=0.
- Push 0x00 and 0xFF back-to-back -> two frames; line high for exactly 4+3 cycles between the stop start and the second start edge; exactly two rd_en pulses.
- Drop tx_en_i at the 3rd data bit of 0x3C -> frame completes correctly; no further rd_en while 2 bytes remain in the FIFO.
- Assert rst_ni low at the 5th data bit -> tx_o=1 within the same cycle (async); after release, state IDLE; the next byte transmits cleanly.
- UART_TX_PARITY_EN defined, send 0x07 -> parity bit 1 after the data bits; send 0x03 -> parity bit 0.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART types, default constants and parity helper.
// Parity support in uart_tx is enabled by defining UART_TX_PARITY_EN.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        REQ    = 3'd1,
        LOAD   = 3'd2,
        START  = 3'd3,
        DATA   = 3'd4,
        PARITY = 3'd5,
        STOP   = 3'd6
    } tx_state_e;

    localparam int DEFAULT_CLKS_PER_BIT = 868;
    localparam int DEFAULT_DATA_BITS    = 8;
    localparam int MAX_DATA_BITS        = 9;

    // Even parity: result makes the total count of ones (payload + parity) even.
    function automatic logic even_parity(input logic [MAX_DATA_BITS-1:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period counter: one-cycle tick at each bit boundary, restartable via clr_i.
// Shared by uart_tx and uart_rx.
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int ClksPerBit = DEFAULT_CLKS_PER_BIT
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    output logic tick_o
);

    localparam int CntW = $clog2(ClksPerBit);
    localparam logic [CntW-1:0] LAST_CNT     = CntW'(ClksPerBit - 1);
    localparam logic [CntW-1:0] PRE_LAST_CNT = CntW'(ClksPerBit - 2);

    logic [CntW-1:0] cnt_r;
    logic            tick_r;

    // Tick is registered one cycle early so it is high while the counter sits at its last value.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_r  <= '0;
            tick_r <= 1'b0;
        end else if (clr_i) begin
            cnt_r  <= '0;
            tick_r <= 1'b0;
        end else if (cnt_r == LAST_CNT) begin
            cnt_r  <= '0;
            tick_r <= 1'b0;
        end else begin
            cnt_r  <= cnt_r + 1'b1;
            tick_r <= (cnt_r == PRE_LAST_CNT);
        end
    end

    assign tick_o = tick_r;

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: pops bytes from the TX FIFO and sends LSB-first 8N1 frames on tx_o.
// Define UART_TX_PARITY_EN to insert an even-parity bit after the data bits.
module uart_tx
    import uart_pkg::*;
#(
    parameter int DataBits   = DEFAULT_DATA_BITS,
    parameter int ClksPerBit = DEFAULT_CLKS_PER_BIT,
    parameter int StopBits   = 1
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                tx_en_i,
    input  logic                fifo_empty_i,
    input  logic [DataBits-1:0] fifo_rd_data_i,
    output logic                fifo_rd_en_o,
    output logic                tx_o,
    output logic                busy_o
);

    localparam int BitCntW = $clog2(DataBits + 1);
    localparam logic [BitCntW-1:0] LAST_DATA_BIT = BitCntW'(DataBits - 1);
    localparam logic [BitCntW-1:0] LAST_STOP_BIT = BitCntW'(StopBits - 1);

    tx_state_e           state_r;
    logic [DataBits-1:0] shift_r;
    logic [BitCntW-1:0]  bit_cnt_r;
    logic                tx_r;
    logic                rd_en_r;
    logic                busy_r;
    logic                baud_clr_s;
    logic                baud_tick_s;
`ifdef UART_TX_PARITY_EN
    logic                parity_r;
`endif

    // The bit period restarts exactly on the edge the start bit is driven.
    assign baud_clr_s = (state_r == LOAD);

    uart_baud_gen #(
        .ClksPerBit(ClksPerBit)
    ) u_baud_gen (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .clr_i (baud_clr_s),
        .tick_o(baud_tick_s)
    );

    // Frame sequencer; every output is driven from a register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r   <= IDLE;
            shift_r   <= '0;
            bit_cnt_r <= '0;
            tx_r      <= 1'b1;
            rd_en_r   <= 1'b0;
            busy_r    <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_r  <= 1'b0;
`endif
        end else begin
            case (state_r)
                IDLE: begin
                    if (tx_en_i && !fifo_empty_i) begin
                        state_r <= REQ;
                        rd_en_r <= 1'b1;
                        busy_r  <= 1'b1;
                    end else begin
                        rd_en_r <= 1'b0;
                        busy_r  <= 1'b0;
                    end
                end
                REQ: begin
                    rd_en_r <= 1'b0;
                    state_r <= LOAD;
                end
                // Byte was popped, so it is sent even if tx_en_i has dropped meanwhile.
                LOAD: begin
                    shift_r <= fifo_rd_data_i;
                    tx_r    <= 1'b0;
                    state_r <= START;
`ifdef UART_TX_PARITY_EN
                    parity_r <= even_parity(MAX_DATA_BITS'(fifo_rd_data_i));
`endif
                end
                START: begin
                    if (baud_tick_s) begin
                        tx_r      <= shift_r[0];
                        bit_cnt_r <= '0;
                        state_r   <= DATA;
                    end
                end
                DATA: begin
                    if (baud_tick_s) begin
                        if (bit_cnt_r == LAST_DATA_BIT) begin
                            bit_cnt_r <= '0;
`ifdef UART_TX_PARITY_EN
                            tx_r      <= parity_r;
                            state_r   <= PARITY;
`else
                            tx_r      <= 1'b1;
                            state_r   <= STOP;
`endif
                        end else begin
                            shift_r   <= shift_r >> 1;
                            tx_r      <= shift_r[1];
                            bit_cnt_r <= bit_cnt_r + 1'b1;
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (baud_tick_s) begin
                        tx_r      <= 1'b1;
                        bit_cnt_r <= '0;
                        state_r   <= STOP;
                    end
                end
`endif
                STOP: begin
                    if (baud_tick_s) begin
                        if (bit_cnt_r == LAST_STOP_BIT) begin
                            state_r <= IDLE;
                            busy_r  <= 1'b0;
                        end else begin
                            bit_cnt_r <= bit_cnt_r + 1'b1;
                        end
                    end
                end
                default: begin
                    state_r <= IDLE;
                    tx_r    <= 1'b1;
                    rd_en_r <= 1'b0;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign fifo_rd_en_o = rd_en_r;
    assign tx_o         = tx_r;
    assign busy_o       = busy_r;

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx (ClksPerBit=4): stimulus queues expected frames, a line monitor checks them.
module tb_uart_tx;

    localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif
    localparam int STOP_GAP = 7;   // one stop bit (4) + 3 cycles of IDLE/REQ/LOAD

    logic       clk_i = 1'b0;
    logic       rst_ni;
    logic       tx_en;
    logic       fifo_empty;
    logic [7:0] fifo_rd_data;
    logic       fifo_rd_en;
    logic       tx_o;
    logic       busy_o;

    logic [7:0]  mem [0:63];
    int          wr_ptr = 0;
    int          rd_ptr = 0;
    int          rd_cnt = 0;
    int          cyc = 0;
    int          total = 0;
    int          bad = 0;
    logic [10:0] exp_q [$];
    int          start_cyc [$];

    uart_tx #(
        .DataBits  (8),
        .ClksPerBit(CPB),
        .StopBits  (1)
    ) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .tx_en_i       (tx_en),
        .fifo_empty_i  (fifo_empty),
        .fifo_rd_data_i(fifo_rd_data),
        .fifo_rd_en_o  (fifo_rd_en),
        .tx_o          (tx_o),
        .busy_o        (busy_o)
    );

    always #5 clk_i = ~clk_i;

    assign fifo_empty = (wr_ptr == rd_ptr);

    // Registered-read FIFO model: data appears the cycle after the pop request.
    always @(posedge clk_i) begin
        cyc <= cyc + 1;
        if (rst_ni && fifo_rd_en) begin
            rd_cnt <= rd_cnt + 1;
            if (wr_ptr != rd_ptr) begin
                fifo_rd_data <= mem[rd_ptr[5:0]];
                rd_ptr       <= rd_ptr + 1;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Push one byte with its hand-computed parity; the expected frame goes to the scoreboard.
    task automatic send(input logic [7:0] b, input logic par);
        mem[wr_ptr[5:0]] = b;
        wr_ptr = wr_ptr + 1;
`ifdef UART_TX_PARITY_EN
        exp_q.push_back({1'b1, par, b, 1'b0});
`else
        exp_q.push_back({1'b0, 1'b1, b, 1'b0});
        if (par) ;
`endif
    endtask

    task automatic wait_idle(input string name);
        logic done;
        done = 1'b0;
        for (int i = 0; i < 400 && !done; i++) begin
            @(posedge clk_i); #1;
            done = (exp_q.size() == 0) && !busy_o && (wr_ptr == rd_ptr);
        end
        check(name, {31'd0, done}, 32'd1);
    endtask

    task automatic wait_fall(input string name);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(posedge clk_i); #1;
            seen = !tx_o;
        end
        check(name, {31'd0, seen}, 32'd1);
    endtask

    // Line monitor: on each start edge pop an expected frame and check every cycle of every bit.
    initial begin : monitor
        logic        prev_tx;
        logic        aborted;
        logic        bit_ok;
        logic [10:0] exp_frame;
        prev_tx = 1'b1;
        forever begin
            @(negedge clk_i);
            if (rst_ni === 1'b1 && prev_tx && tx_o === 1'b0) begin
                start_cyc.push_back(cyc);
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_frame: start at cycle %0d with empty scoreboard", cyc);
                end else begin
                    exp_frame = exp_q.pop_front();
                    aborted = 1'b0;
                    for (int b = 0; b < FRAME_BITS && !aborted; b++) begin
                        bit_ok = 1'b1;
                        for (int s = 0; s < CPB && !aborted; s++) begin
                            if (b != 0 || s != 0) @(negedge clk_i);
                            if (rst_ni !== 1'b1) aborted = 1'b1;
                            else if (tx_o !== exp_frame[b]) bit_ok = 1'b0;
                        end
                        if (!aborted) begin
                            total++;
                            if (!bit_ok) begin
                                bad++;
                                $display("FAIL frame_bit%0d: line differs from %0b (frame %03h)",
                                         b, exp_frame[b], exp_frame);
                            end
                        end
                    end
                end
            end
            prev_tx = (rst_ni === 1'b1) ? tx_o : 1'b1;
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        logic seen;
        logic quiet;
        int   n0;
        int   gap;
        rst_ni = 1'b0;
        tx_en  = 1'b0;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
        check("reset_tx", tx_o, 1);
        check("reset_rd_en", fifo_rd_en, 0);
        check("reset_busy", busy_o, 0);

        // Single 0xA5 frame: request pulse, start two edges later, busy until the stop ends.
        @(posedge clk_i); #1;
        tx_en = 1'b1;
        send(8'hA5, 1'b0);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(posedge clk_i); #1;
            seen = fifo_rd_en;
        end
        check("a5_rd_en_seen", seen, 1);
        @(posedge clk_i); #1;
        check("a5_rd_en_pulse", fifo_rd_en, 0);
        check("a5_tx_idle_in_req", tx_o, 1);
        check("a5_busy_in_req", busy_o, 1);
        @(posedge clk_i); #1;
        check("a5_start_k_plus_2", tx_o, 0);
        repeat (FRAME_BITS * CPB - 1) @(posedge clk_i);
        #1;
        check("a5_busy_last_stop", busy_o, 1);
        @(posedge clk_i); #1;
        check("a5_busy_after_stop", busy_o, 0);
        check("a5_rd_cnt", rd_cnt, 1);

        // Empty FIFO with enable high: nothing happens.
        quiet = 1'b1;
        repeat (100) begin
            @(posedge clk_i); #1;
            if (tx_o !== 1'b1 || busy_o !== 1'b0 || fifo_rd_en !== 1'b0) quiet = 1'b0;
        end
        check("empty_quiet", quiet, 1);
        check("empty_rd_cnt", rd_cnt, 1);

        // Back-to-back 0x00 / 0xFF: minimum line-high gap between frames.
        n0 = start_cyc.size();
        send(8'h00, 1'b0);
        send(8'hFF, 1'b0);
        wait_idle("b2b_done");
        check("b2b_frames", start_cyc.size() - n0, 2);
        gap = (start_cyc.size() >= n0 + 2) ?
              start_cyc[n0 + 1] - start_cyc[n0] - (FRAME_BITS - 1) * CPB : -1;
        check("b2b_high_gap", gap, STOP_GAP);
        check("b2b_rd_cnt", rd_cnt, 3);

        // Enable dropped during the third data bit of 0x3C: frame finishes, no more pops.
        send(8'h3C, 1'b0);
        send(8'h5A, 1'b0);
        send(8'h83, 1'b1);
        wait_fall("dis_start");
        repeat (3 * CPB) @(posedge clk_i);
        #1;
        tx_en = 1'b0;
        repeat (80) @(posedge clk_i);
        #1;
        check("dis_rd_cnt", rd_cnt, 4);
        check("dis_fifo_left", wr_ptr - rd_ptr, 2);
        check("dis_busy", busy_o, 0);
        check("dis_frames_left", exp_q.size(), 2);
        tx_en = 1'b1;
        wait_idle("resume_done");
        check("resume_rd_cnt", rd_cnt, 6);

        // Reset during the fifth data bit of 0x00: line returns high without waiting for a clock.
        send(8'h00, 1'b0);
        wait_fall("rst_start");
        repeat (5 * CPB) @(posedge clk_i);
        #1;
        check("rst_pre_tx", tx_o, 0);
        rst_ni = 1'b0;
        #1;
        check("rst_async_tx", tx_o, 1);
        check("rst_async_busy", busy_o, 0);
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
        check("rst_release_busy", busy_o, 0);
        check("rst_release_tx", tx_o, 1);
        send(8'hC7, 1'b1);
        wait_idle("post_rst_done");
        check("post_rst_rd_cnt", rd_cnt, 8);

`ifdef UART_TX_PARITY_EN
        send(8'h07, 1'b1);
        send(8'h03, 1'b0);
        wait_idle("parity_done");
        check("parity_rd_cnt", rd_cnt, 10);
`endif

        repeat (5) @(posedge clk_i);
        check("scoreboard_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
